// File: rtl/regfile_wr_arbiter.sv
// Two-source writeback arbiter for the 8x16 register file, with a pending-write scoreboard.
// Define REGARB_FIXED_PRIO_EN for fixed priority (load unit wins) instead of round robin.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  localparam int unsigned NREG = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  input  logic [ADDR_W-1:0] REQ0_DA,
  input  logic [DATA_W-1:0] REQ0_D,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [ADDR_W-1:0] REQ1_DA,
  input  logic [DATA_W-1:0] REQ1_D,
  output logic              REQ1_READY,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] ISSUE_DA,
  output logic              ISSUE_READY,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  output logic              A_BUSY,
  output logic              B_BUSY,
  output logic              WR,
  output logic [ADDR_W-1:0] DA,
  output logic [DATA_W-1:0] D,
  output logic [NREG-1:0]   PENDING
);

  logic              grant0;
  logic              grant1;
  logic              issue_fire;
  logic              wr_q;
  logic [ADDR_W-1:0] da_q;
  logic [DATA_W-1:0] d_q;
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;

`ifdef REGARB_FIXED_PRIO_EN
  always_comb begin
    grant1 = !RESET && REQ1_VALID;
    grant0 = !RESET && REQ0_VALID && !REQ1_VALID;
  end
`else
  // ptr_q names the requester that wins the next contested cycle.
  logic ptr_q;

  always_comb begin
    grant0 = !RESET && REQ0_VALID && (!REQ1_VALID || !ptr_q);
    grant1 = !RESET && REQ1_VALID && (!REQ0_VALID || ptr_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q <= 1'b0;
    end else if (REQ0_VALID && REQ1_VALID) begin
      ptr_q <= ~ptr_q;
    end
  end
`endif

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_q <= 1'b0;
      da_q <= '0;
      d_q  <= '0;
    end else begin
      wr_q <= grant0 || grant1;
      if (grant1) begin
        da_q <= REQ1_DA;
        d_q  <= REQ1_D;
      end else if (grant0) begin
        da_q <= REQ0_DA;
        d_q  <= REQ0_D;
      end
    end
  end

  // A write scheduled into a reset cycle is dropped so the file never sees it.
  assign WR = wr_q && !RESET;
  assign DA = da_q;
  assign D  = d_q;

  assign ISSUE_READY = !RESET && !pending_q[ISSUE_DA];
  assign issue_fire  = ISSUE && ISSUE_READY;

  // Set is applied after clear so a same-edge reservation survives the write.
  always_comb begin
    pending_d = pending_q;
    if (WR) begin
      pending_d[da_q] = 1'b0;
    end
    if (issue_fire) begin
      pending_d[ISSUE_DA] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign PENDING = pending_q;
  assign A_BUSY  = pending_q[AA];
  assign B_BUSY  = pending_q[BA];

  a_one_grant: assert property (@(posedge CLK) !(REQ0_READY && REQ1_READY));
  a_no_grant_in_reset: assert property (@(posedge CLK) RESET |-> !(REQ0_READY || REQ1_READY));

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (D/DA/WR) between two writeback sources: REQ0 (ALU writeback) and REQ1 (load unit).
- Tracks which registers have an outstanding write in a pending scoreboard. This lets the issue logic stall on read-after-write hazards on the A/B read addresses.
- Sits between the execute/memory stages and the 8x16 register file. Its outputs drive the file's D, DA and WR inputs directly.

Parameters:
- DATA_W, 16, width of the write data.
- ADDR_W, 3, register address width; number of registers NREG = 2**ADDR_W.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  ALU has a writeback pending.
- REQ0_DA  in  ADDR_W  ALU destination register.
- REQ0_D  in  DATA_W  ALU writeback data.
- REQ0_READY  out  1  REQ0 granted this cycle.
- REQ1_VALID, REQ1_DA, REQ1_D, REQ1_READY: same as REQ0, for the load unit.
- ISSUE  in  1  issue logic reserves a destination register.
- ISSUE_DA  in  ADDR_W  register being reserved.
- ISSUE_READY  out  1  reservation can be accepted this cycle.
- AA  in  ADDR_W  A read address, same value presented to the register file.
- BA  in  ADDR_W  B read address, same value presented to the register file.
- A_BUSY  out  1  PENDING[AA].
- B_BUSY  out  1  PENDING[BA].
- WR  out  1  register-file write enable (registered).
- DA  out  ADDR_W  register-file write address (registered).
- D  out  DATA_W  register-file write data (registered).
- PENDING  out  NREG  scoreboard, one bit per register.

Behaviour:
- Reset (RESET=1 at a rising edge):
  - WR=0, DA=0, D=0, PENDING=0, round-robin pointer = REQ0.
  - While RESET is high, REQ0_READY=0, REQ1_READY=0 and ISSUE_READY=0. No grants, no reservations.
  - Reset mid-transfer discards the transfer; a WR scheduled for the next cycle is suppressed.
- Handshake:
  - A transfer occurs when VALID && READY in the same cycle.
  - READY is combinational from the VALIDs and the pointer. It never depends on the same requester's READY.
  - A requester holds VALID, DA and D stable until READY.
- Arbitration, round robin:
  - Only one VALID: that requester is granted.
  - Both VALID: the requester named by the pointer is granted, and the pointer moves to the other requester.
  - Pointer changes only on a contested grant.
  - At most one READY per cycle.
- Write stage (latency 1):
  - A grant in cycle N produces WR=1 in cycle N+1, with DA/D equal to the granted request's DA/D.
  - WR=0 in any cycle following a cycle with no grant. DA/D hold their last values when WR=0.
  - Back-to-back grants give WR=1 on consecutive cycles; throughput is 1 write per cycle.
- Scoreboard:
  - Set: ISSUE && ISSUE_READY sets PENDING[ISSUE_DA] at the edge.
  - Clear: the edge ending a cycle with WR=1 clears PENDING[DA], coinciding with the register-file write.
  - Set and clear of the same index at the same edge: set wins, and the bit stays 1.
  - ISSUE_READY = !RESET && !PENDING[ISSUE_DA]. A second reservation of an already-pending register is refused (WAW stall).
  - A write to a non-pending register is legal and leaves its bit 0.
  - A_BUSY and B_BUSY are combinational from PENDING. There is no bypass: while WR=1 for a register, its bit is still 1 and that register reads busy.
- Width rules:
  - No arithmetic on data; D is passed unmodified.
  - Pointer is 1 bit.

Optional Feature:
- Macro REGARB_FIXED_PRIO_EN.
- Defined: fixed priority. REQ1 (load) always wins when both are VALID; the pointer register is removed.
- Undefined: round robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: RESET=1 for 2 cycles with both VALIDs high -> READYs=0, WR=0, DA=0, D=0, PENDING=8'h00 throughout; first grant to REQ0 in the cycle after RESET drops.
- Single requester: REQ0 VALID, DA=3, D=16'hBEEF -> REQ0_READY same cycle; next cycle WR=1, DA=3, D=16'hBEEF; following cycle WR=0.
- Contention: both VALID for 4 cycles, REQ0 D=16'h1111, REQ1 D=16'h2222 -> grants REQ0, REQ1, REQ0, REQ1; WR=1 for 4 cycles with D alternating 1111, 2222. With REGARB_FIXED_PRIO_EN defined -> REQ1 granted all 4 cycles.
- Scoreboard: ISSUE DA=5 -> PENDING=8'h20; AA=5 gives A_BUSY=1; REQ1 writes DA=5 -> A_BUSY=1 during the WR cycle, PENDING=8'h00 after that edge.
- Collisions:
  - ISSUE DA=2 in the same cycle as WR=1, DA=2 -> PENDING[2]=1 afterwards.
  - ISSUE DA=2 while PENDING[2]=1 -> ISSUE_READY=0 and no change.
- Reset mid-operation: grant in cycle N, RESET=1 in cycle N+1 -> WR=0 at the edge ending N+1, no register written, PENDING cleared.
